// File: rtl/risc16_pkg.sv
// Shared encodings for the RiSC-16 multi-cycle controller.
// Holds opcodes, ALU/PC/WB select codes, FSM states and the EXEC control bundle.
package risc16_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_NAND  = 2'b01;
    localparam logic [1:0] ALU_PASS1 = 2'b10;
    localparam logic [1:0] ALU_ZERO  = 2'b11;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    // Control produced in EXEC; to_mem/to_halt steer the FSM.
    typedef struct packed {
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       mar_we;
        logic       alu1;
        logic       alu2;
        logic [1:0] func;
        logic       to_mem;
        logic       to_halt;
    } exec_ctl_t;

endpackage

// File: rtl/risc16_exec_decode.sv
// EXEC-state decoder: maps opcode, ALU EQ and the JALR halt qualifier to a control vector.
// Ports: opcode_i (IR[15:13]), eq_i, imm_nz_i in; ctl_o (exec_ctl_t) out.
module risc16_exec_decode
    import risc16_pkg::*;
(
    input  logic [2:0] opcode_i,
    input  logic       eq_i,
    input  logic       imm_nz_i,
    output exec_ctl_t  ctl_o
);

    always_comb begin
        ctl_o        = '0;
        ctl_o.func   = ALU_ZERO;
        ctl_o.wb_sel = WB_ALU;
        ctl_o.pc_sel = PC_INC;
        unique case (opcode_i)
            OP_ADD: begin
                ctl_o.func  = ALU_ADD;
                ctl_o.rf_we = 1'b1;
            end
            OP_ADDI: begin
                ctl_o.alu2  = 1'b1;
                ctl_o.func  = ALU_ADD;
                ctl_o.rf_we = 1'b1;
            end
            OP_NAND: begin
                ctl_o.func  = ALU_NAND;
                ctl_o.rf_we = 1'b1;
            end
            OP_LUI: begin
                ctl_o.alu1  = 1'b1;
                ctl_o.func  = ALU_PASS1;
                ctl_o.rf_we = 1'b1;
            end
            OP_SW, OP_LW: begin
                ctl_o.alu2   = 1'b1;
                ctl_o.func   = ALU_ADD;
                ctl_o.mar_we = 1'b1;
                ctl_o.to_mem = 1'b1;
            end
            OP_BEQ: begin
                ctl_o.func = ALU_ADD;
                if (eq_i) begin
                    ctl_o.pc_we  = 1'b1;
                    ctl_o.pc_sel = PC_BR;
                end
            end
            OP_JALR: begin
                if (imm_nz_i) begin
                    ctl_o.to_halt = 1'b1;
                end else begin
                    // RF captures old PC+1 on the same edge PC loads rB.
                    ctl_o.rf_we  = 1'b1;
                    ctl_o.wb_sel = WB_PC;
                    ctl_o.pc_we  = 1'b1;
                    ctl_o.pc_sel = PC_JALR;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/risc16_ctrl.sv
// Multi-cycle control FSM for RiSC-16: FETCH, DECODE, EXEC, MEM, HALT plus retire counter.
// Ports: clk, rst (async high), opcode, imm_nz, eq, mem_ack in; memory, PC/IR/RF/MAR and ALU controls, halted, retired out.
module risc16_ctrl
    import risc16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             imm_nz,
    input  logic             eq,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             mar_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             MUX_alu1,
    output logic             MUX_alu2,
    output logic [1:0]       FUNC_alu,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    exec_ctl_t        ctl;

    risc16_exec_decode u_exec_decode (
        .opcode_i (opcode),
        .eq_i     (eq),
        .imm_nz_i (imm_nz),
        .ctl_o    (ctl)
    );

    // Outputs are gated by rst so an in-flight request drops
    // the moment reset asserts, not at the next edge.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        mar_we   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_INC;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        MUX_alu1 = 1'b0;
        MUX_alu2 = 1'b0;
        FUNC_alu = ALU_ZERO;
        halted   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pc_sel  = PC_INC;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    rf_we    = ctl.rf_we;
                    wb_sel   = ctl.wb_sel;
                    pc_we    = ctl.pc_we;
                    pc_sel   = ctl.pc_sel;
                    mar_we   = ctl.mar_we;
                    MUX_alu1 = ctl.alu1;
                    MUX_alu2 = ctl.alu2;
                    FUNC_alu = ctl.func;
                    if (ctl.to_mem) begin
                        state_d = S_MEM;
                    end else if (ctl.to_halt) begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (opcode == OP_SW);
                    if (mem_ack) begin
                        if (opcode == OP_LW) begin
                            rf_we  = 1'b1;
                            wb_sel = WB_MEM;
                        end
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    assign retired   = retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_risc16_ctrl.sv
// Scoreboard bench for risc16_ctrl: driver queues per-cycle expected controls,
// a negedge monitor pops and compares; a 4-bit-counter instance checks wrap.
module tb_risc16_ctrl;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        addr_sel;
        logic        mar_we;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        alu1;
        logic        alu2;
        logic [1:0]  func;
        logic        halted;
        logic [15:0] ret;
        logic [3:0]  ret4;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  opcode = 3'd0;
    logic        imm_nz = 1'b0;
    logic        eq = 1'b0;
    logic        mem_ack = 1'b0;

    logic        mem_req, mem_we, addr_sel, mar_we, ir_we, pc_we, rf_we;
    logic [1:0]  pc_sel, wb_sel, FUNC_alu;
    logic        MUX_alu1, MUX_alu2, halted;
    logic [15:0] retired;

    logic        w_mem_req, w_mem_we, w_addr_sel, w_mar_we, w_ir_we, w_pc_we, w_rf_we;
    logic [1:0]  w_pc_sel, w_wb_sel, w_func;
    logic        w_alu1, w_alu2, w_halted;
    logic [3:0]  retired4;

    vec_t        exp_q[$];
    string       tag_q[$];
    logic [15:0] exp_ret = 16'd0;
    int          n_cmp = 0;
    int          n_bad = 0;

    risc16_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imm_nz(imm_nz), .eq(eq),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .mar_we(mar_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .MUX_alu1(MUX_alu1), .MUX_alu2(MUX_alu2), .FUNC_alu(FUNC_alu),
        .halted(halted), .retired(retired)
    );

    risc16_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .imm_nz(imm_nz), .eq(eq),
        .mem_ack(mem_ack), .mem_req(w_mem_req), .mem_we(w_mem_we),
        .addr_sel(w_addr_sel), .mar_we(w_mar_we), .ir_we(w_ir_we),
        .pc_we(w_pc_we), .pc_sel(w_pc_sel), .rf_we(w_rf_we),
        .wb_sel(w_wb_sel), .MUX_alu1(w_alu1), .MUX_alu2(w_alu2),
        .FUNC_alu(w_func), .halted(w_halted), .retired(retired4)
    );

    always #5 clk = ~clk;

    function automatic vec_t actual();
        vec_t a;
        a.mem_req  = mem_req;
        a.mem_we   = mem_we;
        a.addr_sel = addr_sel;
        a.mar_we   = mar_we;
        a.ir_we    = ir_we;
        a.pc_we    = pc_we;
        a.pc_sel   = pc_sel;
        a.rf_we    = rf_we;
        a.wb_sel   = wb_sel;
        a.alu1     = MUX_alu1;
        a.alu2     = MUX_alu2;
        a.func     = FUNC_alu;
        a.halted   = halted;
        a.ret      = retired;
        a.ret4     = retired4;
        return a;
    endfunction

    function automatic vec_t idle();
        vec_t v;
        v      = '0;
        v.func = 2'b11;
        v.ret  = exp_ret;
        v.ret4 = exp_ret[3:0];
        return v;
    endfunction

    task automatic check(input string nm, input vec_t e);
        vec_t        a;
        logic [35:0] ra, re;
        a  = actual();
        ra = a;
        re = e;
        n_cmp++;
        if (ra !== re) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, ra, re, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), exp_q.pop_front());
        end
    end

    task automatic push(input vec_t v, input string nm);
        exp_q.push_back(v);
        tag_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic imm, input logic eqv,
                       input int fw, input int mw, input logic stray,
                       input string nm);
        vec_t v;
        opcode = op;
        imm_nz = imm;
        eq     = eqv;
        for (int i = 0; i < fw; i++) begin
            mem_ack   = 1'b0;
            v         = idle();
            v.mem_req = 1'b1;
            push(v, {nm, "/fetch_wait"});
            step();
        end
        mem_ack   = 1'b1;
        v         = idle();
        v.mem_req = 1'b1;
        v.ir_we   = 1'b1;
        v.pc_we   = 1'b1;
        v.pc_sel  = 2'b00;
        push(v, {nm, "/fetch_ack"});
        step();
        mem_ack = stray;
        v       = idle();
        push(v, {nm, "/decode"});
        step();
        v = idle();
        case (op)
            3'd0: begin v.func = 2'b00; v.rf_we = 1'b1; end
            3'd1: begin v.alu2 = 1'b1; v.func = 2'b00; v.rf_we = 1'b1; end
            3'd2: begin v.func = 2'b01; v.rf_we = 1'b1; end
            3'd3: begin v.alu1 = 1'b1; v.func = 2'b10; v.rf_we = 1'b1; end
            3'd4, 3'd5: begin v.alu2 = 1'b1; v.func = 2'b00; v.mar_we = 1'b1; end
            3'd6: begin
                v.func = 2'b00;
                if (eqv) begin v.pc_we = 1'b1; v.pc_sel = 2'b01; end
            end
            default: begin
                if (!imm) begin
                    v.rf_we  = 1'b1;
                    v.wb_sel = 2'b10;
                    v.pc_we  = 1'b1;
                    v.pc_sel = 2'b10;
                end
            end
        endcase
        push(v, {nm, "/exec"});
        if (op == 3'd4 || op == 3'd5) begin
            step();
            for (int i = 0; i < mw; i++) begin
                mem_ack    = 1'b0;
                v          = idle();
                v.mem_req  = 1'b1;
                v.addr_sel = 1'b1;
                v.mem_we   = (op == 3'd4);
                push(v, {nm, "/mem_wait"});
                step();
            end
            mem_ack    = 1'b1;
            v          = idle();
            v.mem_req  = 1'b1;
            v.addr_sel = 1'b1;
            v.mem_we   = (op == 3'd4);
            if (op == 3'd5) begin
                v.rf_we  = 1'b1;
                v.wb_sel = 2'b01;
            end
            push(v, {nm, "/mem_ack"});
            exp_ret = exp_ret + 16'd1;
            step();
        end else begin
            exp_ret = exp_ret + 16'd1;
            step();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        vec_t v;
        #2;
        check("reset_init", idle());
        #10;
        rst = 1'b0;
        #1;
        v         = idle();
        v.mem_req = 1'b1;
        check("fetch_after_rst", v);
        step();

        run(3'd0, 1'b0, 1'b0, 0, 0, 1'b0, "add");
        run(3'd1, 1'b0, 1'b0, 1, 0, 1'b0, "addi");

        // Abort a pending fetch with reset while retired is non-zero.
        mem_ack   = 1'b0;
        v         = idle();
        v.mem_req = 1'b1;
        push(v, "pre_abort_fetch");
        #6;
        rst = 1'b1;
        #1;
        exp_ret = 16'd0;
        check("rst_mid_fetch", idle());
        #4;
        rst = 1'b0;
        #1;
        v         = idle();
        v.mem_req = 1'b1;
        check("fetch_after_abort", v);
        step();

        run(3'd0, 1'b0, 1'b0, 0, 0, 1'b0, "add0");
        run(3'd5, 1'b0, 1'b0, 3, 2, 1'b0, "lw_wait");
        run(3'd4, 1'b0, 1'b0, 3, 2, 1'b0, "sw_wait");
        run(3'd6, 1'b0, 1'b1, 0, 0, 1'b0, "beq_taken");
        run(3'd6, 1'b0, 1'b0, 0, 0, 1'b0, "beq_not");
        run(3'd3, 1'b0, 1'b0, 1, 0, 1'b0, "lui");
        run(3'd1, 1'b0, 1'b0, 0, 0, 1'b0, "addi2");
        run(3'd2, 1'b0, 1'b0, 2, 0, 1'b0, "nand");
        run(3'd7, 1'b0, 1'b0, 0, 0, 1'b0, "jalr");
        run(3'd0, 1'b0, 1'b0, 0, 0, 1'b1, "add_stray_ack");
        run(3'd5, 1'b0, 1'b0, 0, 0, 1'b0, "lw_zw");
        run(3'd4, 1'b0, 1'b0, 0, 1, 1'b0, "sw_zw");
        run(3'd1, 1'b0, 1'b0, 0, 0, 1'b0, "addi3");
        run(3'd2, 1'b0, 1'b0, 0, 0, 1'b0, "nand2");
        run(3'd3, 1'b0, 1'b0, 0, 0, 1'b0, "lui2");
        run(3'd6, 1'b0, 1'b1, 1, 0, 1'b0, "beq_taken2");
        run(3'd0, 1'b0, 1'b0, 0, 0, 1'b0, "add_wrap16");
        run(3'd6, 1'b0, 1'b0, 0, 0, 1'b0, "beq_not2");
        run(3'd7, 1'b1, 1'b0, 0, 0, 1'b0, "jalr_halt");

        for (int i = 0; i < 20; i++) begin
            mem_ack  = i[0];
            v        = idle();
            v.halted = 1'b1;
            push(v, "halt_hold");
            step();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/risc16_ctrl.md
Name: risc16_ctrl

Overview:
Multi-cycle control FSM for the RiSC-16 core. It sequences fetch, decode, execute, memory and write-back, and drives the ALU operand muxes and the ALU function select. It also drives PC/IR/register-file write enables and a req/ack memory handshake. It sits between the instruction register and the datapath (ALU, register file, PC, MAR), and owns a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  3  IR[15:13]
imm_nz  in  1  IR[6:0] != 0 (JALR halt qualifier)
eq  in  1  ALU EQ output
mem_ack  in  1  memory transaction complete
mem_req  out  1  memory request, held until ack
mem_we  out  1  store qualifier, valid with mem_req
addr_sel  out  1  0=PC, 1=MAR
mar_we  out  1  latch alu_out into MAR
ir_we  out  1  load IR from memory read data
pc_we  out  1  PC write enable
pc_sel  out  2  00=PC+1, 01=PC+imm7 (branch target), 10=rB (JALR)
rf_we  out  1  register-file write enable (rA)
wb_sel  out  2  00=alu_out, 01=mem read data, 10=PC
MUX_alu1  out  1  ALU src1 select, 1=imm<<6
MUX_alu2  out  1  ALU src2 select, 1=sext(imm7)
FUNC_alu  out  2  00=add, 01=nand, 10=pass src1, 11=zero
halted  out  1  core stopped
retired  out  CNT_W  instructions completed, wraps

Behaviour:
- Reset (async, any state): state=FETCH; retired=0; halted=0; all enables/req low; MUX_alu1=MUX_alu2=0; FUNC_alu=11.
- All outputs are Moore/Mealy combinational from state, opcode and eq. Defaults in every state: enables low, FUNC_alu=11, muxes 0.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. Hold until mem_ack. In the ack cycle: ir_we=1, pc_we=1, pc_sel=00; next state DECODE. An ack in the same cycle as req (zero-wait) is legal. mem_req must be low in DECODE.
- DECODE: one cycle, no outputs active; operands settle. Next state EXEC.
- EXEC, by opcode (rf_we writes use wb_sel=00 unless stated; all return to FETCH unless stated):
  - ADD 000: alu1=0, alu2=0, func=00, rf_we=1.
  - ADDI 001: alu2=1, func=00, rf_we=1.
  - NAND 010: func=01, rf_we=1.
  - LUI 011: alu1=1, func=10, rf_we=1.
  - SW 100 / LW 101: alu2=1, func=00, mar_we=1; next state MEM.
  - BEQ 110: alu1=0, alu2=0, func=00. If eq: pc_we=1, pc_sel=01.
  - JALR 111, imm_nz=0: rf_we=1, wb_sel=10, pc_we=1, pc_sel=10. The register file samples the old PC+1 on the same edge the PC loads rB.
  - JALR 111, imm_nz=1: no writes; next state HALT.
- MEM: mem_req=1, addr_sel=1, mem_we=(opcode==SW). Hold until mem_ack. For LW, the ack cycle also asserts rf_we=1, wb_sel=01. Next state FETCH.
- HALT: all enables low, halted=1. Terminal; exit only via rst.
- retired increments by 1 on the edge leaving EXEC to FETCH or to HALT, and on the edge leaving MEM. It wraps modulo 2^CNT_W.
- mem_req is never deasserted before mem_ack. ack while req is low is ignored.
- Unknown states recover to FETCH.
- Reset during MEM or FETCH aborts the transaction; mem_req drops asynchronously.

Decomposition:
- Package risc16_pkg holds:
  - opcode localparams (OP_ADD..OP_JALR);
  - FUNC_alu encodings (ALU_ADD, ALU_NAND, ALU_PASS1, ALU_ZERO);
  - pc_sel and wb_sel encodings;
  - state enum typedef.
- One natural combinational sub-module, risc16_exec_decode: opcode + eq + imm_nz → EXEC-state control vector. The FSM and counter stay in risc16_ctrl.

Test Plan:
- Reset mid-FETCH (mem_req=1, no ack), assert rst → mem_req=0 immediately, retired=0, FUNC_alu=11; after release, FETCH with mem_req=1.
- ADD with zero-wait ack → FETCH(ack: ir_we, pc_we, pc_sel=00), DECODE, EXEC(func=00, muxes 0, rf_we=1); 3 cycles; retired=1.
- LW with ack delayed 3 cycles in FETCH and 2 in MEM → mem_req held throughout each wait; mar_we in EXEC; rf_we=1, wb_sel=01 only in the MEM ack cycle; mem_we=0. SW same flow with mem_we=1, rf_we never asserted.
- BEQ eq=1 → pc_we=1, pc_sel=01 in EXEC; BEQ eq=0 → pc_we=0; both increment retired.
- LUI → MUX_alu1=1, FUNC_alu=10, rf_we=1. ADDI → MUX_alu2=1, FUNC_alu=00. NAND → FUNC_alu=01.
- JALR imm_nz=0 → rf_we=1, wb_sel=10, pc_we=1, pc_sel=10. JALR imm_nz=1 → halted=1, no further mem_req for 20 cycles, retired frozen. Preload retired=0xFFFF → next retire wraps to 0x0000.
